lms_gpio_bidir: RTL
===================

// Module: lms_gpio_bidir
// PURPOSE
// Parametrised Avalon-MM GPIO slave for LMS control lines: per-bit direction, output set/clear,
// synchronised pin readback, edge capture and maskable level interrupt. Sits on the control
// CPU's Avalon bus next to the other peripheral slaves.
// PARAMETERS
// WIDTH        4    number of GPIO bits, 1..32
// RESET_OUT    3    reset value of output data register (WIDTH bits)
// RESET_DIR    '1   reset value of direction register; 1 = output
// EDGE_TYPE    0    0 rising, 1 falling, 2 any edge captured
// SYNC_STAGES  2    input synchroniser depth, 2..4
// PORTS
// clk        in   1      system clock
// reset_n    in   1      asynchronous active-low reset
// address    in   3      register word address
// chipselect in   1      slave select
// write_n    in   1      active-low write strobe
// read_n     in   1      active-low read strobe
// writedata  in   32     write data; bits >= WIDTH ignored
// readdata   out  32     registered read data, bits >= WIDTH read 0
// irq        out  1      level interrupt, |(edge_cap & irq_mask)
// pin_in     in   WIDTH  asynchronous pin inputs
// out_port   out  WIDTH  output data register
// oe         out  WIDTH  output enable = direction register
// BEHAVIOUR
// - Register map: 0 DATA (wr: out data; rd: out data for oe=1 bits, synced pin for oe=0 bits)
//   1 DIR, 2 IRQ_MASK, 3 EDGE_CAP (rd; wr 1 clears bit), 4 OUTSET (wr: out |= wd),
//   5 OUTCLR (wr: out &= ~wd), 6/7 reserved: writes ignored, read 0. OUTSET/OUTCLR read 0.
// - Write accepted when chipselect & ~write_n; takes effect on next clk edge, zero wait states.
// - Read: chipselect & ~read_n samples address; readdata valid the following cycle (latency 1),
//   held until next read. Reads have no side effects.
// - Reset: out_port=RESET_OUT, oe=RESET_DIR, irq_mask=0, edge_cap=0, readdata=0, irq=0,
//   synchroniser and previous-value flops 0.
// - pin_in passes SYNC_STAGES flops, then one previous-value flop; edge = compare per EDGE_TYPE.
// - Arm counter: edge detection suppressed for SYNC_STAGES+1 cycles after reset release so a pin
//   already high at reset does not capture a rising edge. Counter saturates; irrelevant afterwards.
// - edge_cap bit sets on detected edge regardless of direction or mask; stays set until cleared.
// - Same-cycle edge and W1C on one bit: set wins (edge never lost).
// - irq registered: asserts one cycle after edge_cap/mask makes term true; deasserts one cycle
//   after clear or mask write.
// - Pin change to DATA readback latency: SYNC_STAGES+1 cycles (incl. read latency).
// - reset_n asserted mid-operation: all state returns to reset values immediately, pending read
//   data discarded.
// STRUCTURE
// - lms_gpio_pkg: register address constants (ADDR_DATA..ADDR_OUTCLR), edge-type enum.
// - Sub-module lms_gpio_sync: WIDTH-wide SYNC_STAGES flop synchroniser, async reset to 0.
// - Top holds registers, arm counter, edge detector, read mux, irq flop.
// TESTING
// - Reset, no access -> out_port=4'h3, oe=4'hF, irq=0, read addr 2/3 -> 0.
// - Write 0xA addr0, 0x1 addr4, 0x8 addr5 -> out_port 0xA, 0xB, 0x3; readdata 1 cycle after read.
// - DIR=0x0, pin_in=0x5 -> DATA read 0x5 no earlier than SYNC_STAGES+1 cycles after change.
// - pin_in[2] held 1 through reset release -> edge_cap stays 0; later 0->1 -> edge_cap=0x4.
// - irq_mask=0x4, rising on bit2 -> irq=1; W1C 0x4 to addr3 coinciding with new edge -> bit stays set.
// - Write addr6, read addr6/7 -> no state change, readdata 0; reset mid-write -> reset values.

Source files
------------

// File: rtl/lms_gpio_pkg.sv
// lms_gpio_pkg: register map, edge-type encoding and edge helper for the LMS GPIO slave
package lms_gpio_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  typedef enum logic [1:0] {EDGE_RISE = 2'd0, EDGE_FALL = 2'd1, EDGE_ANY = 2'd2} edge_type_e;
  function automatic logic [31:0] edge_detect(edge_type_e t, logic [31:0] cur, logic [31:0] prev);
    return t == EDGE_RISE ? cur & ~prev : t == EDGE_FALL ? ~cur & prev : cur ^ prev;
  endfunction
endpackage

// File: rtl/lms_gpio_bidir_if.sv
// lms_gpio_bidir_if: Avalon-MM slave bus plus level interrupt for the LMS GPIO block
interface lms_gpio_bidir_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master(output address, chipselect, write_n, read_n, writedata, input readdata, irq);
  modport slave(input address, chipselect, write_n, read_n, writedata, output readdata, irq);
endinterface

// File: rtl/lms_gpio_sync.sv
// lms_gpio_sync: WIDTH-wide multi-flop synchroniser for asynchronous pin inputs
module lms_gpio_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sync <= '{default: '0};
    else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/lms_gpio_bidir.sv
// lms_gpio_bidir: Avalon-MM GPIO slave with per-bit direction, set/clear, edge capture and irq
module lms_gpio_bidir
  import lms_gpio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_OUT   = WIDTH'(3),
  parameter logic [WIDTH-1:0] RESET_DIR   = '1,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  lms_gpio_bidir_if.slave  bus,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe
);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARM_CYCLES = AW'(SYNC_STAGES + 1);
  localparam edge_type_e ET = edge_type_e'(EDGE_TYPE[1:0]);
  logic [WIDTH-1:0] w_sync, w_wd, w_edge, w_clr, w_data, w_out_nxt;
  logic [WIDTH-1:0] r_prev, r_out, r_dir, r_mask, r_cap;
  logic [AW-1:0]    r_arm;
  logic             w_wr, w_rd, w_armed, r_irq, w_unused_wd;
  logic [31:0]      w_rmux, r_rdata;
  lms_gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .i_d(pin_in), .o_q(w_sync)
  );
  assign w_unused_wd = ^bus.writedata;
  assign w_wd = bus.writedata[WIDTH-1:0];
  assign w_wr = bus.chipselect & ~bus.write_n;
  assign w_rd = bus.chipselect & ~bus.read_n;
  // Pins already high at reset release must not look like a fresh rising edge
  assign w_armed = r_arm == ARM_CYCLES;
  assign w_edge = w_armed ? WIDTH'(edge_detect(ET, 32'(w_sync), 32'(r_prev))) : '0;
  assign w_clr = (w_wr && bus.address == ADDR_EDGE_CAP) ? w_wd : '0;
  assign w_data = (r_out & r_dir) | (w_sync & ~r_dir);
  always_comb begin
    w_out_nxt = r_out;
    if (w_wr) w_out_nxt = bus.address == ADDR_DATA ? w_wd :
                          bus.address == ADDR_OUTSET ? r_out | w_wd :
                          bus.address == ADDR_OUTCLR ? r_out & ~w_wd : r_out;
    w_rmux = bus.address == ADDR_DATA ? 32'(w_data) :
             bus.address == ADDR_DIR ? 32'(r_dir) :
             bus.address == ADDR_IRQ_MASK ? 32'(r_mask) :
             bus.address == ADDR_EDGE_CAP ? 32'(r_cap) : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_prev  <= '0;
      r_arm   <= '0;
      r_out   <= RESET_OUT;
      r_dir   <= RESET_DIR;
      r_mask  <= '0;
      r_cap   <= '0;
      r_irq   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_prev <= w_sync;
      r_arm  <= w_armed ? r_arm : r_arm + AW'(1);
      r_out  <= w_out_nxt;
      if (w_wr && bus.address == ADDR_DIR) r_dir <= w_wd;
      if (w_wr && bus.address == ADDR_IRQ_MASK) r_mask <= w_wd;
      // A new edge beats a simultaneous write-one-to-clear
      r_cap  <= (r_cap & ~w_clr) | w_edge;
      r_irq  <= |(r_cap & r_mask);
      if (w_rd) r_rdata <= w_rmux;
    end
  assign out_port     = r_out;
  assign oe           = r_dir;
  assign bus.readdata = r_rdata;
  assign bus.irq      = r_irq;
endmodule
